instruction_fetch: RTL and testbench

Front-end stage of the single-cycle CPU. It holds the program counter and a loadable instruction memory, and presents one instruction per cycle to the control/ALU-control/datapath stage. It computes the next PC from sequential, branch and jump inputs returned by that stage, and it sequences start, stall and halt.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/pc_next_logic.sv | 30 +++
 rtl/instruction_fetch.sv | 128 ++++++++++++
 tb/tb_instruction_fetch.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle CPU.
// Holds the halt sentinel, the opcode constants the control unit decodes,
// the fetch-stage state enum and the instruction word size.
package cpu_pkg;

    localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;
    localparam logic [5:0]  OP_J       = 6'h02;
    localparam logic [5:0]  OP_BEQ     = 6'h04;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_HALT
    } fetch_state_e;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection for the fetch stage (purely combinational).
// Ports:
//   pc_plus4      in  32  address of the following word
//   instruction   in  32  currently presented instruction
//   jump          in  1   jump decode for the presented instruction
//   branch_taken  in  1   branch & zero for the presented instruction
//   next_pc       out 32  selected next PC (jump > branch > sequential)
module pc_next_logic (
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instruction,
    input  logic        jump,
    input  logic        branch_taken,
    output logic [31:0] next_pc
);

    logic [31:0] branch_offset;

    // Signed word offset of the branch, scaled to bytes.
    assign branch_offset = {{14{instruction[15]}}, instruction[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = {pc_plus4[31:28], instruction[25:0], 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, loadable instruction memory and start/stall/halt sequencing.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   startin                    start execution at RESET_PC (IDLE/HALT only)
//   stall                      hold PC, do not retire
//   branch_taken, jump         next-PC controls returned by the downstream stage
//   imem_we/waddr/wdata        memory load port (IDLE/HALT only)
//   pc, pc_plus4, instruction  current fetch; instruction is combinational from pc
//   valid                      instruction executable this cycle
//   halted, err                HALT state; sticky out-of-range flag
//   instr_count                saturating retired-instruction count
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          startin,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic                          jump,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [31:0]                   pc,
    output logic [31:0]                   pc_plus4,
    output logic [31:0]                   instruction,
    output logic                          valid,
    output logic                          halted,
    output logic                          err,
    output logic [31:0]                   instr_count
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    logic [31:0]  imem [IMEM_DEPTH];

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         err_q, err_d;

    logic         in_range;
    logic         is_halt;
    logic [31:0]  next_pc;

    assign in_range    = (pc_q[31:2] < 30'(IMEM_DEPTH));
    // Out-of-range reads return zero so the array is never indexed past its end.
    assign instruction = in_range ? imem[pc_q[AW+1:2]] : 32'h0;
    assign pc_plus4    = pc_q + 32'(WORD_BYTES);
    assign is_halt     = (instruction == HALT_WORD);

    assign valid       = (state_q == FETCH_RUN) && in_range && !is_halt;
    assign halted      = (state_q == FETCH_HALT);
    assign err         = err_q;
    assign pc          = pc_q;
    assign instr_count = cnt_q;

    pc_next_logic u_pc_next (
        .pc_plus4     (pc_plus4),
        .instruction  (instruction),
        .jump         (jump),
        .branch_taken (branch_taken),
        .next_pc      (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            FETCH_IDLE: begin
                if (startin) begin
                    state_d = FETCH_RUN;
                    pc_d    = RESET_PC;
                end
            end
            FETCH_RUN: begin
                if (!in_range) begin
                    state_d = FETCH_HALT;
                    err_d   = 1'b1;
                end else if (is_halt) begin
                    // Halt wins over stall/jump/branch and is not counted.
                    state_d = FETCH_HALT;
                end else if (!stall) begin
                    pc_d = next_pc;
                    if (cnt_q != 32'hFFFF_FFFF) begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            FETCH_HALT: begin
                if (startin) begin
                    state_d = FETCH_RUN;
                    pc_d    = RESET_PC;
                    cnt_d   = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Memory survives reset; writes are only accepted while not executing.
    always_ff @(posedge clk) begin
        if (imem_we && !reset && (state_q != FETCH_RUN)) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
    localparam logic [31:0] ADD1  = 32'h012A_4020;
    localparam logic [31:0] ADD2  = 32'h014B_4820;
    localparam logic [31:0] ADD3  = 32'h0109_5020;

    logic        clk;
    logic        reset, startin, stall, branch_taken, jump, imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] pc, pc_plus4, instruction, instr_count;
    logic        valid, halted, err;

    // Small instance for the out-of-range scenario.
    logic        s_reset, s_startin, s_we;
    logic [1:0]  s_waddr;
    logic [31:0] s_wdata;
    logic [31:0] s_pc, s_pc_plus4, s_instruction, s_count;
    logic        s_valid, s_halted, s_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int          m_state;
    logic [31:0] m_pc, m_cnt;
    logic        m_err;
    logic [31:0] m_mem [64];

    instruction_fetch #(.IMEM_DEPTH(64), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .startin(startin), .stall(stall),
        .branch_taken(branch_taken), .jump(jump), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .pc(pc), .pc_plus4(pc_plus4),
        .instruction(instruction), .valid(valid), .halted(halted), .err(err),
        .instr_count(instr_count)
    );

    instruction_fetch #(.IMEM_DEPTH(4), .RESET_PC(32'h0)) dut_small (
        .clk(clk), .reset(s_reset), .startin(s_startin), .stall(1'b0),
        .branch_taken(1'b0), .jump(1'b0), .imem_we(s_we),
        .imem_waddr(s_waddr), .imem_wdata(s_wdata), .pc(s_pc), .pc_plus4(s_pc_plus4),
        .instruction(s_instruction), .valid(s_valid), .halted(s_halted), .err(s_err),
        .instr_count(s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model, then advance one clock edge.
    task automatic step();
        logic        inr, e_valid, do_wr;
        logic [31:0] e_instr, n_pc, n_cnt, p4;
        logic        n_err;
        int          n_state, off;
        logic [5:0]  wa;
        logic [31:0] wd;
        #1;
        inr     = (m_pc >> 2) < 64;
        e_instr = inr ? m_mem[m_pc[7:2]] : 32'h0;
        e_valid = (m_state == S_RUN) && inr && (e_instr != HALTW);
        p4      = m_pc + 32'd4;
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, p4);
        check("instruction", instruction, e_instr);
        check("valid", {31'b0, valid}, {31'b0, e_valid});
        check("halted", {31'b0, halted}, {31'b0, m_state == S_HALT});
        check("err", {31'b0, err}, {31'b0, m_err});
        check("instr_count", instr_count, m_cnt);

        n_state = m_state; n_pc = m_pc; n_cnt = m_cnt; n_err = m_err;
        if (reset) begin
            n_state = S_IDLE; n_pc = 32'h0; n_cnt = 32'h0; n_err = 1'b0;
        end else if (m_state == S_IDLE) begin
            if (startin) begin n_state = S_RUN; n_pc = 32'h0; end
        end else if (m_state == S_HALT) begin
            if (startin) begin
                n_state = S_RUN; n_pc = 32'h0; n_cnt = 32'h0; n_err = 1'b0;
            end
        end else begin
            if (!inr) begin
                n_state = S_HALT; n_err = 1'b1;
            end else if (e_instr == HALTW) begin
                n_state = S_HALT;
            end else if (!stall) begin
                n_cnt = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 32'd1;
                if (jump) begin
                    n_pc = (p4 & 32'hF000_0000) | ((e_instr & 32'h03FF_FFFF) << 2);
                end else if (branch_taken) begin
                    off  = int'($signed(e_instr[15:0]));
                    n_pc = p4 + 32'(off * 4);
                end else begin
                    n_pc = p4;
                end
            end
        end
        do_wr = imem_we && !reset && (m_state != S_RUN);
        wa = imem_waddr;
        wd = imem_wdata;

        @(posedge clk);
        m_state = n_state; m_pc = n_pc; m_cnt = n_cnt; m_err = n_err;
        if (do_wr) m_mem[wa] = wd;
        @(negedge clk);
    endtask

    task automatic write_word(input logic [5:0] a, input logic [31:0] d);
        imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
        step();
        imem_we = 1'b0;
    endtask

    task automatic s_tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; startin = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
        s_reset = 1'b1; s_startin = 1'b0; s_we = 1'b0; s_waddr = '0; s_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_state = S_IDLE; m_pc = 32'h0; m_cnt = 32'h0; m_err = 1'b0;

        // Preload the whole memory while idle.
        for (int i = 0; i < 64; i++) begin
            logic [31:0] d;
            d = $urandom;
            if (d == HALTW) d = 32'h0;
            if (i == 0) d = ADD1;
            if (i == 1) d = ADD2;
            if (i == 2) d = HALTW;
            imem_we = 1'b1; imem_waddr = 6'(i); imem_wdata = d;
            @(posedge clk);
            m_mem[i] = d;
            @(negedge clk);
        end
        imem_we = 1'b0;

        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'b0, valid}, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_err", {31'b0, err}, 32'h0);
        check("rst_count", instr_count, 32'h0);

        // Straight line: ADD, ADD, HALT
        startin = 1'b1; step(); startin = 1'b0;
        check("t1_pc0", pc, 32'h0);
        check("t1_valid0", {31'b0, valid}, 32'h1);
        step();
        check("t1_pc4", pc, 32'h4);
        step();
        check("t1_pc8", pc, 32'h8);
        check("t1_valid8", {31'b0, valid}, 32'h0);
        step();
        check("t1_halted", {31'b0, halted}, 32'h1);
        check("t1_count", instr_count, 32'h2);

        // Stall, backward branch, jump-beats-branch
        write_word(6'd1, 32'h0800_0010);
        write_word(6'd2, 32'h1000_FFFE);
        write_word(6'd16, HALTW);
        startin = 1'b1; step(); startin = 1'b0;
        check("t2_restart_count", instr_count, 32'h0);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_stall_pc", pc, 32'h4);
            check("t2_stall_count", instr_count, 32'h1);
        end
        stall = 1'b0;
        step();
        check("t2_release_pc", pc, 32'h8);
        branch_taken = 1'b1; step(); branch_taken = 1'b0;
        check("t2_branch_back", pc, 32'h4);
        jump = 1'b1; branch_taken = 1'b1; step(); jump = 1'b0; branch_taken = 1'b0;
        check("t2_jump_wins", pc, 32'h40);
        step();
        check("t2_halted", {31'b0, halted}, 32'h1);
        check("t2_count", instr_count, 32'h4);

        // Forward branch
        write_word(6'd2, 32'h1000_0003);
        write_word(6'd6, HALTW);
        startin = 1'b1; step(); startin = 1'b0;
        step(); step();
        branch_taken = 1'b1; step(); branch_taken = 1'b0;
        check("t3_branch_fwd", pc, 32'd24);
        step();

        // Reset mid-run with an ignored write
        write_word(6'd1, ADD2);
        write_word(6'd2, ADD1);
        write_word(6'd3, ADD3);
        startin = 1'b1; step(); startin = 1'b0;
        imem_we = 1'b1; imem_waddr = 6'd1; imem_wdata = 32'hDEAD_BEEF;
        step(); step(); step();
        check("t4_pc12", pc, 32'd12);
        reset = 1'b1; step(); reset = 1'b0; imem_we = 1'b0;
        check("t4_rst_pc", pc, 32'h0);
        check("t4_rst_count", instr_count, 32'h0);
        check("t4_rst_halted", {31'b0, halted}, 32'h0);
        check("t4_rst_valid", {31'b0, valid}, 32'h0);
        startin = 1'b1; step(); startin = 1'b0;
        step();
        check("t4_readback", instruction, ADD2);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom % 64) == 0;
            startin      = ($urandom % 8) == 0;
            stall        = ($urandom % 4) == 0;
            jump         = ($urandom % 32) == 0;
            branch_taken = ($urandom % 16) == 0;
            imem_we      = ($urandom % 4) == 0;
            imem_waddr   = 6'($urandom);
            imem_wdata   = (($urandom % 8) == 0) ? HALTW : $urandom;
            step();
        end
        reset = 1'b0; startin = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        imem_we = 1'b0;

        // Depth-4 memory: run off the end
        s_tick();
        s_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_we = 1'b1; s_waddr = 2'(i); s_wdata = ADD1 + 32'(i);
            s_tick();
        end
        s_we = 1'b0;
        s_startin = 1'b1; s_tick(); s_startin = 1'b0;
        check("oor_pc0", s_pc, 32'h0);
        check("oor_valid0", {31'b0, s_valid}, 32'h1);
        for (int i = 0; i < 4; i++) s_tick();
        check("oor_pc16", s_pc, 32'd16);
        check("oor_valid16", {31'b0, s_valid}, 32'h0);
        check("oor_instr16", s_instruction, 32'h0);
        check("oor_err_early", {31'b0, s_err}, 32'h0);
        check("oor_count", s_count, 32'h4);
        s_tick();
        check("oor_err", {31'b0, s_err}, 32'h1);
        check("oor_halted", {31'b0, s_halted}, 32'h1);
        s_startin = 1'b1; s_tick(); s_startin = 1'b0;
        check("oor_restart_pc", s_pc, 32'h0);
        check("oor_restart_err", {31'b0, s_err}, 32'h0);
        check("oor_restart_count", s_count, 32'h0);
        check("oor_restart_valid", {31'b0, s_valid}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
